// File: rtl/idstage_mt_if.sv
// rtl/idstage_mt_if.sv - decode-side and execute-side handshake bundle of idstage_mt
interface idstage_mt_if #(
  parameter int NTRD = 8,
  parameter int NREG = 32,
  parameter int DW   = 32
);
  localparam int TW = $clog2(NTRD);
  localparam int RW = $clog2(NREG);

  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_trd;
  logic [DW-1:0] in_pc;
  logic [31:0]   in_ins;
  logic [RW-1:0] in_rd_a;
  logic [RW-1:0] in_rd_b;
  logic [RW-1:0] in_wr_reg;
  logic          in_wr_en;

  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_trd;
  logic [DW-1:0] out_pc;
  logic [31:0]   out_ins;
  logic [DW-1:0] out_data_a;
  logic [DW-1:0] out_data_b;
  logic [RW-1:0] out_wr_reg;
  logic          out_wr_en;

  // slave = the issue stage itself; master = decode/execute neighbours
  modport slave (
    input  in_valid, in_trd, in_pc, in_ins, in_rd_a, in_rd_b, in_wr_reg, in_wr_en, out_ready,
    output in_ready, out_valid, out_trd, out_pc, out_ins, out_data_a, out_data_b, out_wr_reg, out_wr_en
  );

  modport master (
    output in_valid, in_trd, in_pc, in_ins, in_rd_a, in_rd_b, in_wr_reg, in_wr_en, out_ready,
    input  in_ready, out_valid, out_trd, out_pc, out_ins, out_data_a, out_data_b, out_wr_reg, out_wr_en
  );
endinterface

// File: rtl/idstage_mt.sv
// rtl/idstage_mt.sv - multithreaded operand-read/issue stage with per-thread register scoreboard
module idstage_mt #(
  parameter int NTRD = 8,
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  idstage_mt_if.slave             bus,
  input  logic                    init_en_i,
  input  logic [$clog2(NTRD)-1:0] init_trd_i,
  input  logic                    flush_i,
  input  logic                    wb_en_i,
  input  logic [$clog2(NTRD)-1:0] wb_trd_i,
  input  logic [$clog2(NREG)-1:0] wb_reg_i,
  input  logic [DW-1:0]           wb_data_i,
  output logic [NTRD-1:0]         sb_busy_o
);
  localparam int TW = $clog2(NTRD);
  localparam int RW = $clog2(NREG);

  typedef struct packed {
    logic [TW-1:0] trd;
    logic [DW-1:0] pc;
    logic [31:0]   ins;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] wr_reg;
    logic          wr_en;
  } out_t;

  logic [DW-1:0]             rf_q [NTRD][NREG];
  logic [NTRD-1:0][NREG-1:0] pend_q, pend_d;
  out_t                      out_q, out_d;
  logic                      out_valid_q, out_valid_d;

  logic            wb_same_trd, wb_hit_a, wb_hit_b, wb_hit_w;
  logic            haz_a, haz_b, haz_w, hazard, accept;
  logic [NREG-1:0] pend_row;
  logic [DW-1:0]   rd_a_data, rd_b_data;

  // A writeback landing this cycle both forwards its data and retires its pending bit
  assign wb_same_trd = wb_en_i && (wb_trd_i == bus.in_trd);
  assign wb_hit_a    = wb_same_trd && (wb_reg_i == bus.in_rd_a);
  assign wb_hit_b    = wb_same_trd && (wb_reg_i == bus.in_rd_b);
  assign wb_hit_w    = wb_same_trd && (wb_reg_i == bus.in_wr_reg);

  assign pend_row = pend_q[bus.in_trd];
  assign haz_a    = (bus.in_rd_a != '0) && pend_row[bus.in_rd_a] && !wb_hit_a;
  assign haz_b    = (bus.in_rd_b != '0) && pend_row[bus.in_rd_b] && !wb_hit_b;
  assign haz_w    = bus.in_wr_en && (bus.in_wr_reg != '0) && pend_row[bus.in_wr_reg] && !wb_hit_w;
  assign hazard   = bus.in_valid && (haz_a || haz_b || haz_w);

  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard && !flush_i && !init_en_i;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    rd_a_data = '0;
    rd_b_data = '0;
    if (bus.in_rd_a != '0) rd_a_data = wb_hit_a ? wb_data_i : rf_q[bus.in_trd][bus.in_rd_a];
    if (bus.in_rd_b != '0) rd_b_data = wb_hit_b ? wb_data_i : rf_q[bus.in_trd][bus.in_rd_b];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_d.trd    = bus.in_trd;
      out_d.pc     = bus.in_pc;
      out_d.ins    = bus.in_ins;
      out_d.a      = rd_a_data;
      out_d.b      = rd_b_data;
      out_d.wr_reg = bus.in_wr_reg;
      out_d.wr_en  = bus.in_wr_en;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Order matters: clears first, then the accept set wins, then thread init wins over all
  always_comb begin
    pend_d = pend_q;
    if (wb_en_i && (wb_reg_i != '0)) pend_d[wb_trd_i][wb_reg_i] = 1'b0;
    if (flush_i && out_valid_q && out_q.wr_en) pend_d[out_q.trd][out_q.wr_reg] = 1'b0;
    if (accept && bus.in_wr_en && (bus.in_wr_reg != '0)) pend_d[bus.in_trd][bus.in_wr_reg] = 1'b1;
    if (init_en_i) pend_d[init_trd_i] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NTRD; t++) begin
        for (int r = 0; r < NREG; r++) rf_q[t][r] <= '0;
      end
    end else begin
      if (wb_en_i && (wb_reg_i != '0)) rf_q[wb_trd_i][wb_reg_i] <= wb_data_i;
      if (init_en_i) begin
        for (int r = 0; r < NREG; r++) rf_q[init_trd_i][r] <= '0;
      end
    end
  end

  always_comb begin
    sb_busy_o = '0;
    for (int t = 0; t < NTRD; t++) sb_busy_o[t] = |pend_q[t];
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_trd    = out_q.trd;
  assign bus.out_pc     = out_q.pc;
  assign bus.out_ins    = out_q.ins;
  assign bus.out_data_a = out_q.a;
  assign bus.out_data_b = out_q.b;
  assign bus.out_wr_reg = out_q.wr_reg;
  assign bus.out_wr_en  = out_q.wr_en;
endmodule

// File: tb/tb_idstage_mt.sv
// tb/tb_idstage_mt.sv - self-checking bench for idstage_mt
module tb_idstage_mt;
  localparam int NTRD = 8;
  localparam int NREG = 32;
  localparam int DW   = 32;

  logic        clk, rst;
  logic        init_en;
  logic [2:0]  init_trd;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_trd;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [7:0]  sb_busy;

  idstage_mt_if #(.NTRD(NTRD), .NREG(NREG), .DW(DW)) bus ();

  idstage_mt #(.NTRD(NTRD), .NREG(NREG), .DW(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .init_en_i(init_en), .init_trd_i(init_trd), .flush_i(flush),
    .wb_en_i(wb_en), .wb_trd_i(wb_trd), .wb_reg_i(wb_reg), .wb_data_i(wb_data),
    .sb_busy_o(sb_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0]  trd;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wr_reg;
    logic        wr_en;
  } exp_t;

  typedef struct {
    logic [2:0]  trd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  typedef struct {
    logic [2:0]  trd;
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  exp_t        sbq[$];
  exp_t        last_acc;
  logic [31:0] mrf [NTRD][NREG];
  logic [31:0] pc_ctr = 32'h100;
  int          n_chk = 0;
  int          n_err = 0;
  vec_t        vt [8];
  wr_t         wt [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon();
    exp_t act, e;
    if (bus.out_valid && bus.out_ready && !flush) begin
      act.trd = bus.out_trd;       act.pc = bus.out_pc;        act.ins = bus.out_ins;
      act.a = bus.out_data_a;      act.b = bus.out_data_b;
      act.wr_reg = bus.out_wr_reg; act.wr_en = bus.out_wr_en;
      n_chk++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %h expected nothing", act);
      end else begin
        e = sbq.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL sb_out: got %h expected %h", act, e);
        end
      end
    end
  endtask

  task automatic clk_step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string nm, input logic [2:0] t, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] wr, input logic we, input logic [31:0] ea, input logic [31:0] eb,
                       input bit acc);
    exp_t e;
    bus.in_trd = t;      bus.in_pc = pc_ctr;  bus.in_ins = pc_ctr ^ 32'h13579BDF;
    bus.in_rd_a = ra;    bus.in_rd_b = rb;    bus.in_wr_reg = wr;  bus.in_wr_en = we;
    bus.in_valid = 1'b1;
    e.trd = t;  e.pc = pc_ctr;  e.ins = pc_ctr ^ 32'h13579BDF;
    e.a = ea;   e.b = eb;       e.wr_reg = wr;  e.wr_en = we;
    @(negedge clk);
    mon();
    chk({nm, "_ready"}, {63'd0, bus.in_ready}, {63'd0, acc});
    if (acc) begin
      sbq.push_back(e);
      last_acc = e;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    pc_ctr += 32'd4;
  endtask

  task automatic wb(input logic [2:0] t, input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_trd = t; wb_reg = r; wb_data = d;
    clk_step();
    wb_en = 1'b0;
    if (r != 5'd0) mrf[t][r] = d;
  endtask

  task automatic clear_model();
    for (int t = 0; t < NTRD; t++) begin
      for (int r = 0; r < NREG; r++) mrf[t][r] = 32'd0;
    end
  endtask

  initial begin
    wt[0] = '{3'd0, 5'd1,  32'hA0000001};
    wt[1] = '{3'd0, 5'd31, 32'hA000001F};
    wt[2] = '{3'd7, 5'd31, 32'hF700001F};
    wt[3] = '{3'd7, 5'd1,  32'hF7000001};
    wt[4] = '{3'd4, 5'd7,  32'hC4000007};
    wt[5] = '{3'd6, 5'd0,  32'hFFFFFFFF};
    wt[6] = '{3'd6, 5'd10, 32'h6000000A};
    vt[0] = '{3'd0, 5'd1,  5'd31, 32'hA0000001, 32'hA000001F};
    vt[1] = '{3'd7, 5'd31, 5'd1,  32'hF700001F, 32'hF7000001};
    vt[2] = '{3'd6, 5'd0,  5'd10, 32'h00000000, 32'h6000000A};
    vt[3] = '{3'd4, 5'd7,  5'd0,  32'hC4000007, 32'h00000000};
    vt[4] = '{3'd1, 5'd1,  5'd1,  32'h00000000, 32'h00000000};
    vt[5] = '{3'd0, 5'd31, 5'd31, 32'hA000001F, 32'hA000001F};
    vt[6] = '{3'd6, 5'd10, 5'd0,  32'h6000000A, 32'h00000000};
    vt[7] = '{3'd5, 5'd1,  5'd31, 32'h00000000, 32'h00000000};

    rst = 1'b0; init_en = 1'b0; init_trd = '0; flush = 1'b0;
    wb_en = 1'b0; wb_trd = '0; wb_reg = '0; wb_data = '0;
    bus.in_valid = 1'b0; bus.in_trd = '0; bus.in_pc = '0; bus.in_ins = '0;
    bus.in_rd_a = '0; bus.in_rd_b = '0; bus.in_wr_reg = '0; bus.in_wr_en = 1'b0;
    bus.out_ready = 1'b1;
    clear_model();

    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_sb_busy", {56'd0, sb_busy}, 64'd0);
    chk("rst_out_data_a", {32'd0, bus.out_data_a}, 64'd0);
    chk("rst_out_pc", {32'd0, bus.out_pc}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    issue("first", 3'd1, 5'd1, 5'd2, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1);

    for (int i = 0; i < 7; i++) wb(wt[i].trd, wt[i].r, wt[i].d);
    for (int i = 0; i < 8; i++)
      issue($sformatf("vec%0d", i), vt[i].trd, vt[i].ra, vt[i].rb, 5'd0, 1'b0, vt[i].ea, vt[i].eb, 1'b1);
    clk_step();

    wb(3'd2, 5'd5, 32'hDEADBEEF);
    issue("rd_after_wb", 3'd2, 5'd5, 5'd0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b1);
    chk("rd_after_wb_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("rd_after_wb_data", {32'd0, bus.out_data_a}, {32'd0, 32'hDEADBEEF});

    wb_en = 1'b1; wb_trd = 3'd1; wb_reg = 5'd3; wb_data = 32'h1234;
    issue("bypass", 3'd1, 5'd0, 5'd3, 5'd0, 1'b0, 32'd0, 32'h1234, 1'b1);
    wb_en = 1'b0;
    mrf[1][3] = 32'h1234;

    issue("haz_set", 3'd0, 5'd0, 5'd0, 5'd7, 1'b1, 32'd0, 32'd0, 1'b1);
    chk("haz_busy_set", {63'd0, sb_busy[0]}, 64'd1);
    issue("haz_block0", 3'd0, 5'd7, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    issue("haz_block1", 3'd0, 5'd7, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    issue("haz_other_trd", 3'd4, 5'd7, 5'd0, 5'd0, 1'b0, mrf[4][7], 32'd0, 1'b1);
    issue("haz_block2", 3'd0, 5'd7, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    wb_en = 1'b1; wb_trd = 3'd0; wb_reg = 5'd7; wb_data = 32'h77;
    issue("haz_release", 3'd0, 5'd7, 5'd0, 5'd0, 1'b0, 32'h77, 32'd0, 1'b1);
    wb_en = 1'b0;
    mrf[0][7] = 32'h77;
    chk("haz_busy_clr", {63'd0, sb_busy[0]}, 64'd0);
    clk_step();

    bus.out_ready = 1'b0;
    issue("hold_a", 3'd6, 5'd10, 5'd0, 5'd0, 1'b0, mrf[6][10], 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      issue("hold_b_wait", 3'd7, 5'd31, 5'd1, 5'd0, 1'b0, mrf[7][31], mrf[7][1], 1'b0);
      chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("hold_pc", {32'd0, bus.out_pc}, {32'd0, last_acc.pc});
      chk("hold_ins", {32'd0, bus.out_ins}, {32'd0, last_acc.ins});
      chk("hold_data_a", {32'd0, bus.out_data_a}, {32'd0, 32'h6000000A});
    end
    bus.out_ready = 1'b1;
    issue("hold_b_go", 3'd7, 5'd31, 5'd1, 5'd0, 1'b0, mrf[7][31], mrf[7][1], 1'b1);
    clk_step();

    bus.out_ready = 1'b0;
    issue("fl_a", 3'd5, 5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 32'd0, 1'b1);
    chk("fl_busy_set", {63'd0, sb_busy[5]}, 64'd1);
    flush = 1'b1;
    clk_step();
    flush = 1'b0;
    chk("fl_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("fl_busy_clr", {63'd0, sb_busy[5]}, 64'd0);
    sbq.delete(0);
    bus.out_ready = 1'b1;
    issue("fl_reuse", 3'd5, 5'd9, 5'd0, 5'd0, 1'b0, mrf[5][9], 32'd0, 1'b1);
    clk_step();

    wb(3'd3, 5'd6, 32'hAAAA);
    wb(3'd3, 5'd2, 32'h55);
    issue("init_pend", 3'd3, 5'd0, 5'd0, 5'd4, 1'b1, 32'd0, 32'd0, 1'b1);
    chk("init_busy_set", {63'd0, sb_busy[3]}, 64'd1);
    init_en = 1'b1; init_trd = 3'd3;
    wb_en = 1'b1; wb_trd = 3'd3; wb_reg = 5'd6; wb_data = 32'hBBBB;
    issue("init_block", 3'd1, 5'd3, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    init_en = 1'b0; wb_en = 1'b0;
    for (int r = 0; r < NREG; r++) mrf[3][r] = 32'd0;
    chk("init_busy_clr", {63'd0, sb_busy[3]}, 64'd0);
    issue("init_rd", 3'd3, 5'd6, 5'd2, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    issue("init_rd4", 3'd3, 5'd4, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    issue("init_other", 3'd1, 5'd3, 5'd0, 5'd0, 1'b0, mrf[1][3], 32'd0, 1'b1);
    clk_step();

    bus.out_ready = 1'b0;
    issue("stall_a", 3'd2, 5'd5, 5'd0, 5'd8, 1'b1, mrf[2][5], 32'd0, 1'b1);
    issue("stall_b", 3'd2, 5'd5, 5'd0, 5'd0, 1'b0, mrf[2][5], 32'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rstmid_pc", {32'd0, bus.out_pc}, 64'd0);
    chk("rstmid_data_a", {32'd0, bus.out_data_a}, 64'd0);
    chk("rstmid_trd", {61'd0, bus.out_trd}, 64'd0);
    chk("rstmid_wr", {58'd0, bus.out_wr_reg, bus.out_wr_en}, 64'd0);
    chk("rstmid_busy", {56'd0, sb_busy}, 64'd0);
    sbq.delete();
    clear_model();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    issue("post_rst", 3'd2, 5'd5, 5'd0, 5'd0, 1'b0, mrf[2][5], 32'd0, 1'b1);
    clk_step();
    clk_step();
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
